// File: rtl/cpu_mem_responder.sv
// Memory-side responder replacing the icache/dcache pair: captures fetch/load/store, stalls the CPU,
// serves data-side then fetch over one word memory port. Optional fetch buffer: ICACHE_LINE_BUF_EN.
module cpu_mem_responder #(
   parameter int unsigned MEM_AWIDTH = 30,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           icache_addr,
   input  logic                  icache_re,
   output logic [31:0]           icache_dout,
   input  logic [31:0]           dcache_addr,
   input  logic                  dcache_re,
   input  logic [3:0]            dcache_we,
   input  logic [31:0]           dcache_din,
   output logic [31:0]           dcache_dout,
   output logic                  stall,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_rw,
   output logic [MEM_AWIDTH-1:0] mem_req_addr,
   output logic [31:0]           mem_req_data,
   output logic [3:0]            mem_req_mask,
   input  logic                  mem_resp_valid,
   input  logic [31:0]           mem_resp_data
);

   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;
   localparam int unsigned AW  = MEM_AWIDTH;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_D_REQ  = 3'd1;
   localparam logic [2:0] ST_D_WAIT = 3'd2;
   localparam logic [2:0] ST_I_REQ  = 3'd3;
   localparam logic [2:0] ST_I_WAIT = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   logic [2:0]     state_q, state_d;
   logic           stall_q, stall_d;
   logic           i_pend_q, i_pend_d;
   logic           d_pend_q, d_pend_d;
   logic [BEW-1:0] d_we_q, d_we_d;
   logic [AW-1:0]  i_waddr_q, i_waddr_d;
   logic [AW-1:0]  d_waddr_q, d_waddr_d;
   logic [DW-1:0]  d_din_q, d_din_d;
   logic [DW-1:0]  icache_dout_q, icache_dout_d;
   logic [DW-1:0]  dcache_dout_q, dcache_dout_d;
   logic           req_valid_q, req_valid_d;
   logic           req_rw_q, req_rw_d;
   logic [AW-1:0]  req_addr_q, req_addr_d;
   logic [DW-1:0]  req_data_q, req_data_d;
   logic [BEW-1:0] req_mask_q, req_mask_d;
   logic           capture;

`ifdef ICACHE_LINE_BUF_EN
   logic           buf_valid_q, buf_valid_d;
   logic [AW-1:0]  buf_addr_q, buf_addr_d;
   logic [DW-1:0]  buf_data_q, buf_data_d;
`endif

   // Word index bits only; byte offset and any bits above the memory range are dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{icache_addr, dcache_addr};

   // Next-state, capture and request generation.
   always_comb begin
      state_d       = state_q;
      stall_d       = stall_q;
      i_pend_d      = i_pend_q;
      d_pend_d      = d_pend_q;
      d_we_d        = d_we_q;
      i_waddr_d     = i_waddr_q;
      d_waddr_d     = d_waddr_q;
      d_din_d       = d_din_q;
      icache_dout_d = icache_dout_q;
      dcache_dout_d = dcache_dout_q;
      req_valid_d   = req_valid_q;
      req_rw_d      = req_rw_q;
      req_addr_d    = req_addr_q;
      req_data_d    = req_data_q;
      req_mask_d    = req_mask_q;
`ifdef ICACHE_LINE_BUF_EN
      buf_valid_d   = buf_valid_q;
      buf_addr_d    = buf_addr_q;
      buf_data_d    = buf_data_q;
`endif

      capture = (state_q == ST_IDLE) && !stall_q;
      if (capture) begin
         i_pend_d  = icache_re;
         d_pend_d  = dcache_re || (dcache_we != '0);
         d_we_d    = dcache_we;
         i_waddr_d = icache_addr[AW+1:2];
         d_waddr_d = dcache_addr[AW+1:2];
         d_din_d   = dcache_din;
`ifdef ICACHE_LINE_BUF_EN
         if (icache_re && buf_valid_q && (buf_addr_q == icache_addr[AW+1:2])) begin
            i_pend_d      = 1'b0;
            icache_dout_d = buf_data_q;
         end
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (capture && d_pend_d) begin
               state_d     = ST_D_REQ;
               stall_d     = 1'b1;
               req_valid_d = 1'b1;
               req_rw_d    = (d_we_d != '0);
               req_addr_d  = d_waddr_d;
               req_data_d  = (d_we_d != '0) ? d_din_d : '0;
               req_mask_d  = d_we_d;
            end else if (capture && i_pend_d) begin
               state_d     = ST_I_REQ;
               stall_d     = 1'b1;
               req_valid_d = 1'b1;
               req_rw_d    = 1'b0;
               req_addr_d  = i_waddr_d;
               req_data_d  = '0;
               req_mask_d  = '0;
            end
         end
         ST_D_REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               if (d_we_q != '0) begin
`ifdef ICACHE_LINE_BUF_EN
                  if (buf_valid_q && (buf_addr_q == d_waddr_q)) begin
                     buf_valid_d = 1'b0;
                  end
`endif
                  if (i_pend_q) begin
                     state_d     = ST_I_REQ;
                     req_valid_d = 1'b1;
                     req_rw_d    = 1'b0;
                     req_addr_d  = i_waddr_q;
                     req_data_d  = '0;
                     req_mask_d  = '0;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d = ST_D_WAIT;
               end
            end
         end
         ST_D_WAIT: begin
            if (mem_resp_valid) begin
               dcache_dout_d = mem_resp_data;
               if (i_pend_q) begin
                  state_d     = ST_I_REQ;
                  req_valid_d = 1'b1;
                  req_rw_d    = 1'b0;
                  req_addr_d  = i_waddr_q;
                  req_data_d  = '0;
                  req_mask_d  = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_I_REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = ST_I_WAIT;
            end
         end
         ST_I_WAIT: begin
            if (mem_resp_valid) begin
               icache_dout_d = mem_resp_data;
`ifdef ICACHE_LINE_BUF_EN
               buf_valid_d   = 1'b1;
               buf_addr_d    = i_waddr_q;
               buf_data_d    = mem_resp_data;
`endif
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            stall_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            stall_d     = 1'b0;
            req_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         stall_q       <= 1'b0;
         i_pend_q      <= 1'b0;
         d_pend_q      <= 1'b0;
         d_we_q        <= '0;
         i_waddr_q     <= '0;
         d_waddr_q     <= '0;
         d_din_q       <= '0;
         icache_dout_q <= NOP_INST;
         dcache_dout_q <= '0;
         req_valid_q   <= 1'b0;
         req_rw_q      <= 1'b0;
         req_addr_q    <= '0;
         req_data_q    <= '0;
         req_mask_q    <= '0;
      end else begin
         state_q       <= state_d;
         stall_q       <= stall_d;
         i_pend_q      <= i_pend_d;
         d_pend_q      <= d_pend_d;
         d_we_q        <= d_we_d;
         i_waddr_q     <= i_waddr_d;
         d_waddr_q     <= d_waddr_d;
         d_din_q       <= d_din_d;
         icache_dout_q <= icache_dout_d;
         dcache_dout_q <= dcache_dout_d;
         req_valid_q   <= req_valid_d;
         req_rw_q      <= req_rw_d;
         req_addr_q    <= req_addr_d;
         req_data_q    <= req_data_d;
         req_mask_q    <= req_mask_d;
      end
   end

`ifdef ICACHE_LINE_BUF_EN
   // One-entry fetch buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end
`endif

   assign icache_dout   = icache_dout_q;
   assign dcache_dout   = dcache_dout_q;
   assign stall         = stall_q;
   assign mem_req_valid = req_valid_q;
   assign mem_req_rw    = req_rw_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_data  = req_data_q;
   assign mem_req_mask  = req_mask_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder; memory side is driven step by step from the initial block.
module tb_cpu_mem_responder;

   localparam int unsigned AW = 30;

   logic          clk;
   logic          reset;
   logic [31:0]   icache_addr;
   logic          icache_re;
   logic [31:0]   icache_dout;
   logic [31:0]   dcache_addr;
   logic          dcache_re;
   logic [3:0]    dcache_we;
   logic [31:0]   dcache_din;
   logic [31:0]   dcache_dout;
   logic          stall;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_rw;
   logic [AW-1:0] mem_req_addr;
   logic [31:0]   mem_req_data;
   logic [3:0]    mem_req_mask;
   logic          mem_resp_valid;
   logic [31:0]   mem_resp_data;

   int n_chk  = 0;
   int n_fail = 0;
   int n_acc  = 0;
   int n_wr   = 0;
   logic [31:0] last_addr;
   logic        last_rw;

   cpu_mem_responder #(.MEM_AWIDTH(AW), .NOP_INST(32'h0000_0013)) dut (
      .clk(clk), .reset(reset),
      .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
      .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
      .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted memory request.
   always @(posedge clk) begin
      if (reset && mem_req_valid && mem_req_ready) begin
         n_acc++;
         if (mem_req_rw) n_wr++;
         last_addr = 32'(mem_req_addr);
         last_rw   = mem_req_rw;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int acc0;
      reset = 1'b0;
      icache_addr = '0; icache_re = 1'b0;
      dcache_addr = '0; dcache_re = 1'b0; dcache_we = '0; dcache_din = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick(); tick();

      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_rw", 32'(mem_req_rw), 32'd0);
      chk("rst_addr", 32'(mem_req_addr), 32'd0);
      chk("rst_data", mem_req_data, 32'd0);
      chk("rst_mask", 32'(mem_req_mask), 32'd0);
      chk("rst_idout", icache_dout, 32'h0000_0013);
      chk("rst_ddout", dcache_dout, 32'd0);
      reset = 1'b1;
      tick();
      chk("idle_nostall", 32'(stall), 32'd0);

      // Fetch 0x100, response two cycles after acceptance.
      mem_req_ready = 1'b1;
      icache_re = 1'b1; icache_addr = 32'h0000_0100;
      tick();
      icache_re = 1'b0; icache_addr = 32'h0000_0FFC;
      chk("f_stall", 32'(stall), 32'd1);
      chk("f_valid", 32'(mem_req_valid), 32'd1);
      chk("f_rw", 32'(mem_req_rw), 32'd0);
      chk("f_addr", 32'(mem_req_addr), 32'h40);
      tick();
      chk("f_valid_drop", 32'(mem_req_valid), 32'd0);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      chk("f_stall_done", 32'(stall), 32'd1);
      tick();
      chk("f_stall_low", 32'(stall), 32'd0);
      chk("f_idout", icache_dout, 32'hDEAD_BEEF);
      chk("f_nacc", 32'(n_acc), 32'd1);
      chk("f_lastaddr", last_addr, 32'h40);

      // Load 0x204 and fetch 0x104 together: data side first.
      dcache_re = 1'b1; dcache_addr = 32'h0000_0204;
      icache_re = 1'b1; icache_addr = 32'h0000_0104;
      tick();
      dcache_re = 1'b0; icache_re = 1'b0; dcache_addr = '0; icache_addr = '0;
      chk("li_d_addr", 32'(mem_req_addr), 32'h81);
      chk("li_d_rw", 32'(mem_req_rw), 32'd0);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      chk("li_ddout", dcache_dout, 32'h1111_2222);
      chk("li_i_valid", 32'(mem_req_valid), 32'd1);
      chk("li_i_addr", 32'(mem_req_addr), 32'h41);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h3333_4444;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick();
      chk("li_stall_low", 32'(stall), 32'd0);
      chk("li_idout", icache_dout, 32'h3333_4444);
      chk("li_ddout_hold", dcache_dout, 32'h1111_2222);
      chk("li_nacc", 32'(n_acc), 32'd3);
      chk("li_lastaddr", last_addr, 32'h41);

      // Store with ready held low for three cycles.
      mem_req_ready = 1'b0;
      dcache_we = 4'b0011; dcache_din = 32'h0000_ABCD; dcache_addr = 32'h0000_0208;
      tick();
      dcache_we = '0; dcache_din = 32'hFFFF_FFFF; dcache_addr = 32'h0000_0FF0;
      for (int i = 0; i < 3; i++) begin
         chk("st_valid", 32'(mem_req_valid), 32'd1);
         chk("st_rw", 32'(mem_req_rw), 32'd1);
         chk("st_addr", 32'(mem_req_addr), 32'h82);
         chk("st_data", mem_req_data, 32'h0000_ABCD);
         chk("st_mask", 32'(mem_req_mask), 32'h3);
         tick();
      end
      chk("st_nacc_held", 32'(n_acc), 32'd3);
      mem_req_ready = 1'b1;
      tick();
      chk("st_accepted", 32'(n_acc), 32'd4);
      chk("st_valid_drop", 32'(mem_req_valid), 32'd0);
      chk("st_stall_done", 32'(stall), 32'd1);
      tick();
      chk("st_stall_low", 32'(stall), 32'd0);
      chk("st_ddout_hold", dcache_dout, 32'h1111_2222);

      // Read and write enables together act as a single store.
      dcache_re = 1'b1; dcache_we = 4'hF; dcache_din = 32'hCAFE_F00D; dcache_addr = 32'h0000_030C;
      tick();
      dcache_re = 1'b0; dcache_we = '0; dcache_din = '0; dcache_addr = '0;
      chk("rw_rw", 32'(mem_req_rw), 32'd1);
      chk("rw_mask", 32'(mem_req_mask), 32'hF);
      chk("rw_addr", 32'(mem_req_addr), 32'hC3);
      tick();
      tick();
      chk("rw_stall_low", 32'(stall), 32'd0);
      chk("rw_nwr", 32'(n_wr), 32'd2);
      chk("rw_nacc", 32'(n_acc), 32'd5);
      // Stray response while idle must be ignored.
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD_0BAD;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick();
      chk("rw_ddout_hold", dcache_dout, 32'h1111_2222);
      chk("stray_idout", icache_dout, 32'h3333_4444);
      chk("stray_stall", 32'(stall), 32'd0);

      // Minimum latency load: capture, accept, response, then stall drops.
      dcache_re = 1'b1; dcache_addr = 32'h0000_0010;
      tick();
      dcache_re = 1'b0; dcache_addr = '0;
      chk("ml_stall_e0", 32'(stall), 32'd1);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h55AA_55AA;
      chk("ml_addr", last_addr, 32'h4);
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      chk("ml_stall_e2", 32'(stall), 32'd1);
      tick();
      chk("ml_stall_e3", 32'(stall), 32'd0);
      chk("ml_ddout", dcache_dout, 32'h55AA_55AA);

`ifdef ICACHE_LINE_BUF_EN
      // Second fetch of the same word is served from the buffer; a store invalidates it.
      icache_re = 1'b1; icache_addr = 32'h0000_0200;
      tick();
      icache_re = 1'b0; icache_addr = '0;
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick();
      acc0 = n_acc;
      icache_re = 1'b1; icache_addr = 32'h0000_0200;
      tick();
      icache_re = 1'b0; icache_addr = '0;
      chk("buf_hit_stall", 32'(stall), 32'd0);
      chk("buf_hit_valid", 32'(mem_req_valid), 32'd0);
      chk("buf_hit_idout", icache_dout, 32'h7777_7777);
      tick();
      chk("buf_hit_nacc", 32'(n_acc), 32'(acc0));
      dcache_we = 4'hF; dcache_din = 32'h1234_5678; dcache_addr = 32'h0000_0200;
      tick();
      dcache_we = '0; dcache_din = '0; dcache_addr = '0;
      tick();
      tick();
      icache_re = 1'b1; icache_addr = 32'h0000_0200;
      tick();
      icache_re = 1'b0; icache_addr = '0;
      chk("buf_inv_valid", 32'(mem_req_valid), 32'd1);
      chk("buf_inv_addr", 32'(mem_req_addr), 32'h80);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h9999_9999;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick();
      chk("buf_inv_idout", icache_dout, 32'h9999_9999);
      chk("buf_inv_nacc", 32'(n_acc), 32'(acc0 + 2));
`else
      acc0 = n_acc;
`endif

      // Reset in the middle of a load wait; late response is ignored.
      dcache_re = 1'b1; dcache_addr = 32'h0000_0040;
      tick();
      dcache_re = 1'b0; dcache_addr = '0;
      tick();
      chk("mr_in_wait", 32'(stall), 32'd1);
      reset = 1'b0;
      #1;
      chk("mr_stall", 32'(stall), 32'd0);
      chk("mr_valid", 32'(mem_req_valid), 32'd0);
      chk("mr_idout", icache_dout, 32'h0000_0013);
      tick();
      reset = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'hBADB_AD00;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick();
      chk("mr_ddout", dcache_dout, 32'd0);
      chk("mr_stall_after", 32'(stall), 32'd0);
      chk("mr_valid_after", 32'(mem_req_valid), 32'd0);
      chk("mr_idout_after", icache_dout, 32'h0000_0013);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
